// File: rtl/piece_controller.sv
// piece_controller: active tetromino mover with handshaked collision checks.
// Gravity, player moves, spawn and lock for a configurable playfield.
module piece_controller #(
  parameter int COORD_W        = 5,
  parameter int CELLS          = 4,
  parameter int GRID_W         = 10,
  parameter int GRID_H         = 20,
  parameter int GRAVITY_FRAMES = 30,
  parameter int SOFT_FRAMES    = 3,
  parameter int PIVOT          = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic [31:0]              keycode,
  input  logic                     spawn,
  input  logic [CELLS*COORD_W-1:0] spawn_x,
  input  logic [CELLS*COORD_W-1:0] spawn_y,
  input  logic                     check_ack,
  input  logic                     check_ok,
  output logic [CELLS*COORD_W-1:0] x_block,
  output logic [CELLS*COORD_W-1:0] y_block,
  output logic                     piece_valid,
  output logic [1:0]               orientation,
  output logic [CELLS*COORD_W-1:0] cand_x,
  output logic [CELLS*COORD_W-1:0] cand_y,
  output logic                     check_req,
  output logic                     lock_pulse,
  output logic                     game_over
);

  localparam int SW = COORD_W + 2;
  localparam int PW = CELLS * COORD_W;
  localparam int PO = (CELLS - 1 - PIVOT) * COORD_W;
  localparam logic signed [SW-1:0] GW_S = SW'(GRID_W);
  localparam logic signed [SW-1:0] GH_S = SW'(GRID_H);

  localparam int K_J = 4;
  localparam int K_L = 3;
  localparam int K_A = 2;
  localparam int K_D = 1;
  localparam int K_S = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_ACT, S_CHECK, S_WAIT, S_GRAV
  } state_t;

  typedef enum logic [2:0] {
    MV_NONE, MV_L, MV_R, MV_RL, MV_RR, MV_DN
  } mv_t;

  typedef enum logic [1:0] {
    OP_GRAV, OP_SHIFT, OP_ROTL, OP_ROTR
  } op_t;

  state_t          state_q, state_d;
  logic [2:0]      fs_q;
  logic            tick;
  logic [PW-1:0]   x_q, x_d, y_q, y_d;
  logic [PW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic            oob_q, oob_d;
  op_t             op_q, op_d;
  logic            valid_q, valid_d;
  logic [1:0]      ori_q, ori_d;
  logic            req_q, req_d;
  logic            lock_q, lock_d;
  logic            over_q, over_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [4:0]      keys_q, keys_d;
  logic [4:0]      keys_now, kedge;
  logic [5:0]      limit;
  mv_t             act_mv, mv;
  op_t             act_op;
  logic [PW-1:0]   mx, my;
  logic            m_oob;
  logic signed [SW-1:0] px, py, xs, ys, nx, ny;

  function automatic logic hit(input logic [31:0] kc, input logic [7:0] code);
    hit = (kc[7:0] == code) | (kc[15:8] == code) |
          (kc[23:16] == code) | (kc[31:24] == code);
  endfunction

  assign keys_now = {hit(keycode, 8'h0D), hit(keycode, 8'h0F),
                     hit(keycode, 8'h04), hit(keycode, 8'h07),
                     hit(keycode, 8'h16)};
  assign kedge = keys_now & ~keys_q;
  assign limit = keys_q[K_S] ? 6'(SOFT_FRAMES) : 6'(GRAVITY_FRAMES);
  assign tick  = fs_q[1] & ~fs_q[2];

  // Synchronise the frame strobe and keep its previous level for edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) fs_q <= '0;
    else       fs_q <= {fs_q[1:0], frame_clk};
  end

  // Pick at most one player action per frame, rotations first
  always_comb begin
    act_mv = MV_NONE;
    act_op = OP_SHIFT;
    if (kedge[K_J]) begin
      act_mv = MV_RL;
      act_op = OP_ROTL;
    end else if (kedge[K_L]) begin
      act_mv = MV_RR;
      act_op = OP_ROTR;
    end else if (kedge[K_A]) begin
      act_mv = MV_L;
    end else if (kedge[K_D]) begin
      act_mv = MV_R;
    end
  end

  // Candidate generator in widened signed space so off-grid cells are visible
  always_comb begin
    mv    = (state_q == S_GRAV) ? MV_DN : act_mv;
    px    = signed'({2'b00, x_q[PO +: COORD_W]});
    py    = signed'({2'b00, y_q[PO +: COORD_W]});
    mx    = '0;
    my    = '0;
    m_oob = 1'b0;
    xs    = '0;
    ys    = '0;
    nx    = '0;
    ny    = '0;
    for (int i = 0; i < CELLS; i++) begin
      xs = signed'({2'b00, x_q[(CELLS-1-i)*COORD_W +: COORD_W]});
      ys = signed'({2'b00, y_q[(CELLS-1-i)*COORD_W +: COORD_W]});
      nx = xs;
      ny = ys;
      unique case (mv)
        MV_L:  nx = xs - SW'(1);
        MV_R:  nx = xs + SW'(1);
        MV_DN: ny = ys + SW'(1);
        MV_RL: begin
          nx = px + (ys - py);
          ny = py - (xs - px);
        end
        MV_RR: begin
          nx = px - (ys - py);
          ny = py + (xs - px);
        end
        default: ;
      endcase
      if (nx[SW-1] || ny[SW-1] || nx >= GW_S || ny >= GH_S)
        m_oob = 1'b1;
      mx[(CELLS-1-i)*COORD_W +: COORD_W] = nx[COORD_W-1:0];
      my[(CELLS-1-i)*COORD_W +: COORD_W] = ny[COORD_W-1:0];
    end
  end

  // Controller state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Controller next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q && valid_q)
          state_d = S_ACT;
        else if (spawn && !valid_q && !over_q)
          state_d = S_SPAWN;
      end
      S_SPAWN: if (req_q && check_ack) state_d = S_IDLE;
      S_ACT:   state_d = (act_mv == MV_NONE) ? S_GRAV : S_CHECK;
      S_CHECK: begin
        if (!oob_q)              state_d = S_WAIT;
        else if (op_q == OP_GRAV) state_d = S_IDLE;
        else                     state_d = S_GRAV;
      end
      S_WAIT: begin
        if (req_q && check_ack)
          state_d = (op_q == OP_GRAV) ? S_IDLE : S_GRAV;
      end
      S_GRAV: state_d = (cnt_q >= limit) ? S_CHECK : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates driven by the current controller state
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    oob_d   = oob_q;
    op_d    = op_q;
    valid_d = valid_q;
    ori_d   = ori_q;
    req_d   = req_q;
    lock_d  = 1'b0;
    over_d  = over_q;
    cnt_d   = cnt_q;
    keys_d  = keys_q;
    pend_d  = pend_q | tick;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q && valid_q) begin
          pend_d = tick;
        end else if (spawn && !valid_q && !over_q) begin
          cx_d  = spawn_x;
          cy_d  = spawn_y;
          req_d = 1'b1;
        end
      end
      S_SPAWN: begin
        if (req_q && check_ack) begin
          req_d = 1'b0;
          if (check_ok) begin
            x_d     = cx_q;
            y_d     = cy_q;
            valid_d = 1'b1;
            ori_d   = 2'd0;
            cnt_d   = '0;
          end else begin
            over_d = 1'b1;
          end
        end
      end
      S_ACT: begin
        keys_d = keys_now;
        cnt_d  = cnt_q + 6'd1;
        if (act_mv != MV_NONE) begin
          cx_d  = mx;
          cy_d  = my;
          oob_d = m_oob;
          op_d  = act_op;
        end
      end
      S_CHECK: begin
        if (!oob_q) begin
          req_d = 1'b1;
        end else if (op_q == OP_GRAV) begin
          lock_d  = 1'b1;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (req_q && check_ack) begin
          req_d = 1'b0;
          if (check_ok) begin
            x_d = cx_q;
            y_d = cy_q;
            if (op_q == OP_ROTL) ori_d = ori_q + 2'd1;
            if (op_q == OP_ROTR) ori_d = ori_q - 2'd1;
          end else if (op_q == OP_GRAV) begin
            lock_d  = 1'b1;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_GRAV: begin
        if (cnt_q >= limit) begin
          cx_d  = mx;
          cy_d  = my;
          oob_d = m_oob;
          op_d  = OP_GRAV;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any candidate in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q     <= '0;
      y_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      oob_q   <= 1'b0;
      op_q    <= OP_GRAV;
      valid_q <= 1'b0;
      ori_q   <= 2'd0;
      req_q   <= 1'b0;
      lock_q  <= 1'b0;
      over_q  <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      keys_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      oob_q   <= oob_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      ori_q   <= ori_d;
      req_q   <= req_d;
      lock_q  <= lock_d;
      over_q  <= over_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      keys_q  <= keys_d;
    end
  end

  assign x_block     = x_q;
  assign y_block     = y_q;
  assign cand_x      = cx_q;
  assign cand_y      = cy_q;
  assign piece_valid = valid_q;
  assign orientation = ori_q;
  assign check_req   = req_q;
  assign lock_pulse  = lock_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_piece_controller.sv
// tb_piece_controller: directed checks of spawn, gravity, moves, lock,
// delayed acknowledge, reset mid-handshake and game over.
module tb_piece_controller;

  localparam int PW = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_clk;
  logic [31:0]   keycode;
  logic          spawn;
  logic [PW-1:0] spawn_x, spawn_y;
  logic          check_ack, check_ok;
  logic [PW-1:0] x_block, y_block, cand_x, cand_y;
  logic          piece_valid;
  logic [1:0]    orientation;
  logic          check_req, lock_pulse, game_over;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  logic ok_val = 1'b1;
  int req_rises = 0;
  int lock_cnt = 0;
  int unstable = 0;
  int wait_cnt = 0;
  logic req_prev = 1'b0;
  logic [2*PW-1:0] cand_cap = '0;

  always #10 Clk = ~Clk;

  piece_controller dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .spawn       (spawn),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .check_ack   (check_ack),
    .check_ok    (check_ok),
    .x_block     (x_block),
    .y_block     (y_block),
    .piece_valid (piece_valid),
    .orientation (orientation),
    .cand_x      (cand_x),
    .cand_y      (cand_y),
    .check_req   (check_req),
    .lock_pulse  (lock_pulse),
    .game_over   (game_over)
  );

  function automatic logic [PW-1:0] pk(input int a, input int b,
                                       input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    cyc(6);
    frame_clk = 1'b0;
    cyc(30);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic do_spawn(input logic [PW-1:0] sx, input logic [PW-1:0] sy);
    @(negedge Clk);
    spawn_x = sx;
    spawn_y = sy;
    spawn   = 1'b1;
    @(negedge Clk);
    spawn = 1'b0;
    cyc(6);
  endtask

  // Collision checker model plus handshake/lock monitors
  initial begin
    check_ack = 1'b0;
    check_ok  = 1'b0;
    forever begin
      @(negedge Clk);
      if (lock_pulse) lock_cnt++;
      if (check_req && !req_prev) req_rises++;
      req_prev = check_req;
      if (Reset) begin
        check_ack = 1'b0;
        wait_cnt  = 0;
      end else if (check_ack) begin
        check_ack = 1'b0;
        wait_cnt  = 0;
      end else if (check_req) begin
        if (wait_cnt == 0) cand_cap = {cand_x, cand_y};
        else if ({cand_x, cand_y} !== cand_cap) unstable++;
        if (wait_cnt >= ack_delay) begin
          check_ack = 1'b1;
          check_ok  = ok_val;
        end
        wait_cnt++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;
    Reset = 1'b1; frame_clk = 1'b0; keycode = '0;
    spawn = 1'b0; spawn_x = '0; spawn_y = '0;
    cyc(3);
    Reset = 1'b0;
    cyc(2);
    chk("rst_xy", 64'({x_block, y_block}), 64'd0);
    chk("rst_cand", 64'({cand_x, cand_y}), 64'd0);
    chk("rst_flags", 64'({piece_valid, orientation, check_req,
                          lock_pulse, game_over}), 64'd0);

    do_spawn(pk(3, 4, 5, 6), pk(4, 4, 4, 4));
    chk("spawn_x", 64'(x_block), 64'(pk(3, 4, 5, 6)));
    chk("spawn_y", 64'(y_block), 64'(pk(4, 4, 4, 4)));
    chk("spawn_valid", 64'(piece_valid), 64'd1);
    chk("spawn_ori", 64'(orientation), 64'd0);

    frames(29);
    chk("grav_29", 64'(y_block), 64'(pk(4, 4, 4, 4)));
    frame();
    chk("grav_30", 64'(y_block), 64'(pk(5, 5, 5, 5)));
    chk("grav_30_x", 64'(x_block), 64'(pk(3, 4, 5, 6)));

    // J: pivot (4,5), x'=px+(y-py), y'=py-(x-px)
    keycode = 32'h0000_000D;
    frame();
    chk("rotl_x", 64'(x_block), 64'(pk(4, 4, 4, 4)));
    chk("rotl_y", 64'(y_block), 64'(pk(6, 5, 4, 3)));
    chk("rotl_ori", 64'(orientation), 64'd1);
    r0 = req_rises;
    frames(10);
    chk("hold_y", 64'(y_block), 64'(pk(6, 5, 4, 3)));
    chk("hold_ori", 64'(orientation), 64'd1);
    chk("hold_noreq", 64'(req_rises), 64'(r0));

    // L in the top byte rotates back to horizontal
    keycode = 32'h0F00_0000;
    frame();
    chk("rotr_x", 64'(x_block), 64'(pk(3, 4, 5, 6)));
    chk("rotr_y", 64'(y_block), 64'(pk(5, 5, 5, 5)));
    chk("rotr_ori", 64'(orientation), 64'd0);
    keycode = '0;
    frame();

    for (int i = 0; i < 3; i++) begin
      keycode = 32'h0000_0400;
      frame();
      keycode = '0;
      frame();
    end
    chk("left3_x", 64'(x_block), 64'(pk(0, 1, 2, 3)));
    r0 = req_rises;
    keycode = 32'h0004_0000;
    frame();
    chk("left_wall_x", 64'(x_block), 64'(pk(0, 1, 2, 3)));
    chk("left_wall_noreq", 64'(req_rises), 64'(r0));
    keycode = '0;
    frame();

    // Soft drop: first frame drops, then every third frame
    keycode = 32'h0000_0016;
    frames(40);
    chk("soft_y19", 64'(y_block), 64'(pk(19, 19, 19, 19)));
    chk("soft_valid", 64'(piece_valid), 64'd1);
    frames(2);
    chk("prelock_cnt", 64'(lock_cnt), 64'd0);
    r0 = req_rises;
    frame();
    chk("lock_once", 64'(lock_cnt), 64'd1);
    chk("lock_valid", 64'(piece_valid), 64'd0);
    chk("lock_noreq", 64'(req_rises), 64'(r0));
    chk("lock_pos", 64'({x_block, y_block}),
        64'({pk(0, 1, 2, 3), pk(19, 19, 19, 19)}));
    keycode = '0;

    do_spawn(pk(3, 4, 5, 6), pk(0, 0, 0, 0));
    chk("respawn_valid", 64'(piece_valid), 64'd1);
    frames(27);
    ack_delay = 20;
    keycode = 32'h0000_0004;
    r0 = req_rises;
    unstable = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!check_req && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("late_req_up", 64'(check_req), 64'd1);
    frame_clk = 1'b0; cyc(3);
    frame_clk = 1'b1; cyc(3);
    frame_clk = 1'b0; cyc(3);
    frame_clk = 1'b1; cyc(3);
    frame_clk = 1'b0;
    chk("late_req_held", 64'(check_req), 64'd1);
    n = 0;
    while (check_req && n < 60) begin
      @(negedge Clk);
      n++;
    end
    chk("late_req_down", 64'(check_req), 64'd0);
    chk("late_cand_stable", 64'(unstable), 64'd0);
    chk("late_x", 64'(x_block), 64'(pk(2, 3, 4, 5)));
    cyc(40);
    chk("late_pending_y", 64'(y_block), 64'(pk(0, 0, 0, 0)));
    chk("late_one_req", 64'(req_rises), 64'(r0 + 1));
    ack_delay = 0;
    keycode = '0;
    frame();
    chk("late_kept_drop", 64'(y_block), 64'(pk(1, 1, 1, 1)));

    // Reset while a request is outstanding
    ack_delay = 20;
    keycode = 32'h0000_0007;
    @(negedge Clk);
    frame_clk = 1'b1;
    n = 0;
    while (!check_req && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("mid_req_up", 64'(check_req), 64'd1);
    cyc(3);
    frame_clk = 1'b0;
    #3 Reset = 1'b1;
    #1;
    chk("mid_rst_req", 64'(check_req), 64'd0);
    chk("mid_rst_state", 64'({piece_valid, x_block}), 64'd0);
    cyc(2);
    Reset = 1'b0;
    ack_delay = 0;
    keycode = '0;
    cyc(2);

    ok_val = 1'b0;
    do_spawn(pk(3, 4, 5, 6), pk(0, 0, 0, 0));
    chk("over_set", 64'(game_over), 64'd1);
    chk("over_valid", 64'(piece_valid), 64'd0);
    ok_val = 1'b1;
    r0 = req_rises;
    do_spawn(pk(3, 4, 5, 6), pk(0, 0, 0, 0));
    chk("over_ignore_req", 64'(req_rises), 64'(r0));
    chk("over_ignore_valid", 64'(piece_valid), 64'd0);
    chk("over_sticky", 64'(game_over), 64'd1);
    Reset = 1'b1;
    cyc(2);
    chk("over_reset", 64'(game_over), 64'd0);
    Reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
